// File: rtl/bfly_r2_pipe.sv
// -----------------------------------------------------------------------------
// bfly_r2_pipe
//
// Three-stage pipelined radix-2 DIT butterfly:
//   X1 = A + W*B,  X2 = A - W*B
// on complex two's-complement samples. W is a signed Q1.(TW-1) twiddle.
// Each beat may request a rounded divide-by-2. Results are saturated to DW
// bits, and a sticky flag records any saturation.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input stream handshake (in_ready = pipeline enable)
//   ar, ai, br, bi        A and B samples, DW bits each
//   wr, wi                twiddle, TW bits each
//   scale                 per-beat divide-by-2 with round-half-up
//   out_valid / out_ready output stream handshake
//   x1r, x1i, x2r, x2i    butterfly results, DW bits each
//   ovf                   sticky saturation flag
//   clr_ovf               synchronous clear of ovf (a new saturation wins)
// -----------------------------------------------------------------------------
module bfly_r2_pipe #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] ar,
    input  logic [DW-1:0] ai,
    input  logic [DW-1:0] br,
    input  logic [DW-1:0] bi,
    input  logic [TW-1:0] wr,
    input  logic [TW-1:0] wi,
    input  logic          scale,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] x1r,
    output logic [DW-1:0] x1i,
    output logic [DW-1:0] x2r,
    output logic [DW-1:0] x2i,
    output logic          ovf,
    input  logic          clr_ovf
);

    localparam int PW = DW + TW;      // single product
    localparam int SW = PW + 1;       // sum/difference of two products
    localparam int RW = DW + 2;       // rounded W*B component
    localparam int AW = DW + 3;       // A +/- W*B

    // Rounding constant: half an LSB of the Q(TW-1) result.
    localparam logic signed [SW-1:0] RND    = {{(SW-1){1'b0}}, 1'b1} << (TW - 2);
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // The whole pipeline advances together; a stalled full output stage
    // freezes every stage behind it, bubbles included.
    logic en;
    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    // ---------------------------------------------------------------- stage 1
    logic                 v1, sc1;
    logic signed [DW-1:0] a1r, a1i;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    // NOTE: datapath registers are reset too, so outputs read 0 after reset
    // and hold a deterministic value while no beat is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            sc1  <= 1'b0;
            a1r  <= '0;
            a1i  <= '0;
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                sc1  <= scale;
                a1r  <= ar;
                a1i  <= ai;
                p_rr <= PW'($signed(br)) * PW'($signed(wr));
                p_ii <= PW'($signed(bi)) * PW'($signed(wi));
                p_ri <= PW'($signed(br)) * PW'($signed(wi));
                p_ir <= PW'($signed(bi)) * PW'($signed(wr));
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic signed [SW-1:0] sum_r, sum_i;
    logic signed [RW-1:0] wb_r_d, wb_i_d;

    // NOTE: every always_comb output gets a value on every path, which keeps
    // synthesis from inferring latches.
    always_comb begin
        sum_r  = SW'(p_rr) - SW'(p_ii) + RND;
        sum_i  = SW'(p_ri) + SW'(p_ir) + RND;
        // Dropping the Q(TW-1) fraction; the result always fits in DW+2 bits.
        wb_r_d = RW'(sum_r >>> (TW - 1));
        wb_i_d = RW'(sum_i >>> (TW - 1));
    end

    logic                 v2, sc2;
    logic signed [DW-1:0] a2r, a2i;
    logic signed [RW-1:0] wb_r, wb_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            sc2  <= 1'b0;
            a2r  <= '0;
            a2i  <= '0;
            wb_r <= '0;
            wb_i <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                sc2  <= sc1;
                a2r  <= a1r;
                a2i  <= a1i;
                wb_r <= wb_r_d;
                wb_i <= wb_i_d;
            end
        end
    end

    // ---------------------------------------------------------------- stage 3
    // Optional round-half-up halving, then saturation. Bit DW of the result
    // flags that the value was clipped.
    function automatic logic [DW:0] finish_comp(input logic signed [AW-1:0] s,
                                                input logic                 half);
        logic signed [AW-1:0] t;
        t = half ? ((s + AW'(1)) >>> 1) : s;
        if (t > SAT_HI)
            return {1'b1, SAT_HI[DW-1:0]};
        else if (t < SAT_LO)
            return {1'b1, SAT_LO[DW-1:0]};
        else
            return {1'b0, t[DW-1:0]};
    endfunction

    logic signed [AW-1:0] s1r, s1i, s2r, s2i;
    logic [DW:0]          f1r, f1i, f2r, f2i;
    logic                 sat_any;

    always_comb begin
        s1r     = AW'(a2r) + AW'(wb_r);
        s1i     = AW'(a2i) + AW'(wb_i);
        s2r     = AW'(a2r) - AW'(wb_r);
        s2i     = AW'(a2i) - AW'(wb_i);
        f1r     = finish_comp(s1r, sc2);
        f1i     = finish_comp(s1i, sc2);
        f2r     = finish_comp(s2r, sc2);
        f2i     = finish_comp(s2i, sc2);
        sat_any = f1r[DW] | f1i[DW] | f2r[DW] | f2i[DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x1r       <= '0;
            x1i       <= '0;
            x2r       <= '0;
            x2i       <= '0;
        end else if (en) begin
            out_valid <= v2;
            if (v2) begin
                x1r <= f1r[DW-1:0];
                x1i <= f1i[DW-1:0];
                x2r <= f2r[DW-1:0];
                x2i <= f2i[DW-1:0];
            end
        end
    end

    // Setting takes priority so a saturation is never lost to a clear
    // issued in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (en && v2 && sat_any)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

endmodule

// File: tb/tb_bfly_r2_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for bfly_r2_pipe: directed cases plus random traffic with random
// backpressure. Accepted beats push the reference result into a scoreboard;
// an independent monitor pops and compares each output transfer.
// -----------------------------------------------------------------------------
module tb_bfly_r2_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] ar, ai, br, bi;
    logic [TW-1:0] wr, wi;
    logic          scale, clr_ovf, ovf;
    logic [DW-1:0] x1r, x1i, x2r, x2i;

    bfly_r2_pipe #(.DW(DW), .TW(TW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ar       (ar),
        .ai       (ai),
        .br       (br),
        .bi       (bi),
        .wr       (wr),
        .wi       (wi),
        .scale    (scale),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x1r      (x1r),
        .x1i      (x1i),
        .x2r      (x2r),
        .x2i      (x2i),
        .ovf      (ovf),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint x1r, x1i, x2r, x2i;
        bit     sat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Floor division, so arithmetic right shifts are modelled exactly.
    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && ((n < 0) != (d < 0)))
            q = q - 1;
        return q;
    endfunction

    // Reference butterfly in plain integer arithmetic.
    function automatic exp_t model(input longint a_r, input longint a_i,
                                   input longint b_r, input longint b_i,
                                   input longint w_r, input longint w_i,
                                   input bit sc);
        exp_t   e;
        longint one, wbr, wbi, hi, lo;
        longint s[4];
        one = longint'(1) << (TW - 1);
        hi  = (longint'(1) << (DW - 1)) - 1;
        lo  = -(longint'(1) << (DW - 1));
        wbr = fdiv(b_r * w_r - b_i * w_i + one / 2, one);
        wbi = fdiv(b_r * w_i + b_i * w_r + one / 2, one);
        s[0] = a_r + wbr;
        s[1] = a_i + wbi;
        s[2] = a_r - wbr;
        s[3] = a_i - wbi;
        e.sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sc) s[k] = fdiv(s[k] + 1, 2);
            if (s[k] > hi) begin s[k] = hi; e.sat = 1'b1; end
            if (s[k] < lo) begin s[k] = lo; e.sat = 1'b1; end
        end
        e.x1r = s[0];
        e.x1i = s[1];
        e.x2r = s[2];
        e.x2i = s[3];
        return e;
    endfunction

    function automatic longint rnd_s(input int w);
        longint v;
        v = longint'($urandom_range(0, (1 << w) - 1));
        if (v >= (longint'(1) << (w - 1)))
            v = v - (longint'(1) << w);
        return v;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input longint a_r, input longint a_i,
                        input longint b_r, input longint b_i,
                        input longint w_r, input longint w_i,
                        input bit sc);
        longint tmp;
        int     waited;
        tmp = a_r; ar = tmp[DW-1:0];
        tmp = a_i; ai = tmp[DW-1:0];
        tmp = b_r; br = tmp[DW-1:0];
        tmp = b_i; bi = tmp[DW-1:0];
        tmp = w_r; wr = tmp[TW-1:0];
        tmp = w_i; wi = tmp[TW-1:0];
        scale    = sc;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        if (in_ready)
            sb.push_back(model(a_r, a_i, b_r, b_i, w_r, w_i, sc));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid rises (accept edge = 1).
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: a transfer happens at the next rising edge when both are high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("x1r", $signed(x1r), e.x1r);
                    check("x1i", $signed(x1i), e.x1i);
                    check("x2r", $signed(x2r), e.x2r);
                    check("x2i", $signed(x2i), e.x2i);
                    if (e.sat) check("ovf_on_sat", ovf, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int            lat;
        bit            done;
        int            seen;
        logic [DW-1:0] snap1r, snap2i;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_ovf  = 1'b0;
        scale    = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0; wr = '0; wi = '0;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_x1r", x1r, 0);
        check("rst_x2i", x2i, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity twiddle.
        send(100, 200, 1000, -500, 32767, 0, 1'b0);
        wait_out(lat);
        check("latency", lat, 3);
        check("id_x1r", $signed(x1r), 1100);
        check("id_x1i", $signed(x1i), -300);
        check("id_x2r", $signed(x2r), -900);
        check("id_x2i", $signed(x2i), 700);
        check("id_ovf", ovf, 0);
        idle(3);

        // W = -j, X2 real saturates.
        send(0, 0, 32767, -32768, 0, -32768, 1'b0);
        wait_out(lat);
        check("sat_x1r", $signed(x1r), -32768);
        check("sat_x1i", $signed(x1i), -32767);
        check("sat_x2r", $signed(x2r), 32767);
        check("sat_x2i", $signed(x2i), 32767);
        check("sat_ovf", ovf, 1);
        idle(3);
        check("sat_ovf_held", ovf, 1);

        // Same beat halved: no saturation, ovf unchanged.
        send(0, 0, 32767, -32768, 0, -32768, 1'b1);
        wait_out(lat);
        check("scl_x1r", $signed(x1r), -16384);
        check("scl_x1i", $signed(x1i), -16383);
        check("scl_x2r", $signed(x2r), 16384);
        check("scl_x2i", $signed(x2i), 16384);
        check("scl_ovf", ovf, 1);
        idle(3);

        // clr_ovf with nothing in flight.
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check("clr_ovf_clears", ovf, 0);

        // clr_ovf in the cycle a saturating beat loads the output stage.
        send(0, 0, 32767, -32768, 0, -32768, 1'b0);
        @(posedge clk);
        #1;
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check("clr_vs_set_valid", out_valid, 1);
        check("clr_vs_set_ovf", ovf, 1);
        idle(3);

        // Backpressure: five back-to-back beats, out_ready low from cycle 2.
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(rnd_s(DW), rnd_s(DW), rnd_s(DW), rnd_s(DW),
                         rnd_s(TW), rnd_s(TW), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(posedge clk);
                #1;
                check("bp_out_valid", out_valid, 1);
                check("bp_in_ready_low", in_ready, 0);
                snap1r = x1r;
                snap2i = x2i;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check("bp_hold_valid", out_valid, 1);
                    check("bp_hold_ready", in_ready, 0);
                    check("bp_hold_x1r", x1r, snap1r);
                    check("bp_hold_x2i", x2i, snap2i);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    idle($urandom_range(0, 1));
                    send(rnd_s(DW), rnd_s(DW), rnd_s(DW), rnd_s(DW),
                         rnd_s(TW), rnd_s(TW), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        idle(2);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++)
            send(rnd_s(DW), rnd_s(DW), rnd_s(DW), rnd_s(DW), 32767, -32768, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_ovf", ovf, 0);
        check("mrst_x1r", x1r, 0);
        check("mrst_x2i", x2i, 0);
        check("mrst_in_ready", in_ready, 1);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mrst_no_stale", seen, 0);
        @(posedge clk);
        #1;
        send(-300, 50, 7, -9, -32768, 12345, 1'b0);
        wait_out(lat);
        check("mrst_latency", lat, 3);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
